// File: rtl/check_seq_multi_pkg.sv
// check_seq_pkg: shared types, LFSR constants and counter helper for the multi-channel sequence checker.
package check_seq_pkg;
  typedef enum logic {WAIT, RUN} state_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as a bit mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    return (v == (32'hFFFF_FFFF >> (32 - w))) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/check_seq_multi_if.sv
// check_seq_multi_if: bundled per-channel valid/ready/data stream feeding the checker.
interface check_seq_multi_if #(parameter int NCH = 4, parameter int DW = 32);
  logic [NCH-1:0] up_valid;
  logic [NCH*DW-1:0] up_data;
  logic [NCH-1:0] up_ready;
  modport master(output up_valid, output up_data, input up_ready);
  modport slave(input up_valid, input up_data, output up_ready);
endinterface

// File: rtl/check_seq_multi_chan.sv
// check_seq_chan: one channel -- 2-entry skid stage, hold throttle, sequence FSM and saturating counters.
// CHECK_SEQ_LFSR_STALL_EN adds a per-channel LFSR that randomly stalls the consumer.
module check_seq_chan
  import check_seq_pkg::*;
#(
  parameter int DW = 32,
  parameter int DELAY = 0,
  parameter int STEP = 1,
  parameter int CW = 16
`ifdef CHECK_SEQ_LFSR_STALL_EN
  , parameter int CH = 0
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_ready,
  output logic [CW-1:0] o_beat_cnt,
  output logic [CW-1:0] o_err_cnt,
  output logic          o_err_pulse,
  output logic          o_err_flag
);
  localparam int HW = DELAY > 0 ? $clog2(DELAY + 1) : 1;
  logic [DW-1:0] r_mem [2];
  logic          r_wp, r_rp;
  logic [1:0]    r_cnt;
  logic [HW-1:0] r_hold;
  logic [DW-1:0] r_exp;
  state_t        r_state, w_state_nxt;
  logic          w_push, w_pop, w_stall, w_mis;
  logic [1:0]    w_cnt_nxt;
  logic [DW-1:0] w_data;

  assign w_push    = i_valid & o_ready;
  assign w_pop     = (r_cnt != 2'd0) & (r_hold == '0) & ~w_stall;
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  assign w_data    = r_mem[r_rp];

`ifdef CHECK_SEQ_LFSR_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk)
    r_lfsr <= rst ? LFSR_SEED ^ 16'(CH) : {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  assign w_stall = r_lfsr[1:0] == 2'b00;
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_state_nxt = w_pop ? RUN : r_state;
    w_mis       = w_pop && (r_state == RUN) && (w_data != r_exp);
  end

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_cnt       <= 2'd0;
      r_hold      <= '0;
      o_ready     <= 1'b0;
      r_state     <= WAIT;
      r_exp       <= '0;
      o_beat_cnt  <= '0;
      o_err_cnt   <= '0;
      o_err_pulse <= 1'b0;
      o_err_flag  <= 1'b0;
    end else begin
      r_wp        <= r_wp ^ w_push;
      r_rp        <= r_rp ^ w_pop;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_pop ? HW'(DELAY) : (r_hold != '0 ? r_hold - HW'(1) : r_hold);
      o_ready     <= w_cnt_nxt != 2'd2;
      r_state     <= w_state_nxt;
      // a match means data == exp, so both WAIT seeding and resync collapse to data+STEP
      r_exp       <= w_pop ? w_data + DW'(STEP) : r_exp;
      o_beat_cnt  <= clr ? '0 : (w_pop ? CW'(sat_inc(32'(o_beat_cnt), CW)) : o_beat_cnt);
      o_err_cnt   <= clr ? '0 : (w_mis ? CW'(sat_inc(32'(o_err_cnt), CW)) : o_err_cnt);
      o_err_pulse <= w_mis;
      o_err_flag  <= ~clr & (o_err_flag | w_mis);
    end
  end
endmodule

// File: rtl/check_seq_multi.sv
// check_seq_multi: NCH independent stream sequence checkers with a global sticky error flag.
// CHECK_SEQ_LFSR_STALL_EN enables pseudo-random consumer stalls in every channel.
module check_seq_multi
  import check_seq_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW = 32,
  parameter int DELAY = 0,
  parameter int STEP = 1,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  check_seq_multi_if.slave    up,
  input  logic                clr,
  output logic [NCH*CW-1:0]   beat_cnt,
  output logic [NCH*CW-1:0]   err_cnt,
  output logic [NCH-1:0]      err_pulse,
  output logic                err_any
);
  logic [NCH-1:0] w_err_flag;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    check_seq_chan #(
      .DW(DW), .DELAY(DELAY), .STEP(STEP), .CW(CW)
`ifdef CHECK_SEQ_LFSR_STALL_EN
      , .CH(i)
`endif
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .i_valid    (up.up_valid[i]),
      .i_data     (up.up_data[i*DW +: DW]),
      .o_ready    (up.up_ready[i]),
      .o_beat_cnt (beat_cnt[i*CW +: CW]),
      .o_err_cnt  (err_cnt[i*CW +: CW]),
      .o_err_pulse(err_pulse[i]),
      .o_err_flag (w_err_flag[i])
    );
  end

  assign err_any = |w_err_flag;
endmodule

// File: tb/tb_check_seq_multi.sv
// tb_check_seq_multi: directed checks on three configurations (default, DELAY=3, DW=8/CW=4).
module tb_check_seq_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;

  check_seq_multi_if #(.NCH(4), .DW(32)) m_if ();
  check_seq_multi_if #(.NCH(4), .DW(32)) s_if ();
  check_seq_multi_if #(.NCH(4), .DW(8))  n_if ();

  logic [127:0] m_beat, m_err, s_beat, s_err;
  logic [15:0]  n_beat, n_err;
  logic [3:0]   m_pulse, s_pulse, n_pulse;
  logic         m_any, s_any, n_any;

  check_seq_multi #(.NCH(4), .DW(32), .DELAY(0), .STEP(1), .CW(16)) u_m (
    .clk(clk), .rst(rst), .up(m_if), .clr(clr),
    .beat_cnt(m_beat), .err_cnt(m_err), .err_pulse(m_pulse), .err_any(m_any));
  check_seq_multi #(.NCH(4), .DW(32), .DELAY(3), .STEP(1), .CW(16)) u_s (
    .clk(clk), .rst(rst), .up(s_if), .clr(clr),
    .beat_cnt(s_beat), .err_cnt(s_err), .err_pulse(s_pulse), .err_any(s_any));
  check_seq_multi #(.NCH(4), .DW(8), .DELAY(0), .STEP(1), .CW(4)) u_n (
    .clk(clk), .rst(rst), .up(n_if), .clr(clr),
    .beat_cnt(n_beat), .err_cnt(n_err), .err_pulse(n_pulse), .err_any(n_any));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // presents one beat and returns 1ns after the edge that accepted it; valid stays high
  task automatic send(input int inst, input int ch, input logic [31:0] d, output int cyc);
    logic r;
    cyc = 0;
    case (inst)
      0: begin m_if.up_valid[ch] = 1'b1; m_if.up_data[ch*32 +: 32] = d; end
      1: begin s_if.up_valid[ch] = 1'b1; s_if.up_data[ch*32 +: 32] = d; end
      default: begin n_if.up_valid[ch] = 1'b1; n_if.up_data[ch*8 +: 8] = d[7:0]; end
    endcase
    do begin
      @(negedge clk);
      r = inst == 0 ? m_if.up_ready[ch] : (inst == 1 ? s_if.up_ready[ch] : n_if.up_ready[ch]);
      @(posedge clk);
      #1;
      cyc++;
    end while (!r && cyc < 200);
    if (!r) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: inst %0d ch %0d not accepted after %0d cycles", inst, ch, cyc);
    end
  endtask

  // data must stay put while valid && !ready on the throttled channel
  logic [31:0] p_d = '0;
  logic        p_stall = 1'b0;
  always @(negedge clk) begin
    if (p_stall) chk("s_hold_data", s_if.up_data[95:64], p_d);
    p_stall <= s_if.up_valid[2] & ~s_if.up_ready[2];
    p_d     <= s_if.up_data[95:64];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc, tot;
    m_if.up_valid = '0; m_if.up_data = '0;
    s_if.up_valid = '0; s_if.up_data = '0;
    n_if.up_valid = '0; n_if.up_data = '0;
    tick(3);
    chk("rst_ready", m_if.up_ready, 0);
    chk("rst_beat", |m_beat, 0);
    chk("rst_pulse", m_pulse, 0);
    chk("rst_any", m_any, 0);
    rst = 1'b0;
    chk("rst_fall_ready", m_if.up_ready, 0);
    tick(1);
    chk("ready_up", m_if.up_ready, 4'hF);
    chk("ready_up_s", s_if.up_ready, 4'hF);

    // back-to-back stream on ch0
    tot = 0;
    for (int i = 0; i < 100; i++) begin
      send(0, 0, i, cyc);
      tot += cyc;
    end
    m_if.up_valid[0] = 1'b0;
    chk("t1_cycles", tot, 100);
    chk("t1_beat_lag", m_beat[15:0], 99);
    tick(1);
    chk("t1_beat", m_beat[15:0], 100);
    chk("t1_err", m_err[15:0], 0);

    // skipped value on ch1
    send(0, 1, 5, cyc);
    send(0, 1, 6, cyc);
    send(0, 1, 7, cyc);
    send(0, 1, 9, cyc);
    m_if.up_valid[1] = 1'b0;
    chk("t2_pulse_early", m_pulse[1], 0);
    tick(1);
    chk("t2_pulse", m_pulse[1], 1);
    chk("t2_err", m_err[31:16], 1);
    chk("t2_any", m_any, 1);
    tick(1);
    chk("t2_pulse_once", m_pulse[1], 0);
    send(0, 1, 10, cyc);
    m_if.up_valid[1] = 1'b0;
    tick(2);
    chk("t2_resync_err", m_err[31:16], 1);
    chk("t2_beat", m_beat[31:16], 5);

    // reset with beats in flight on every channel
    m_if.up_data = {32'd4000, 32'd3000, 32'd2000, 32'd1000};
    m_if.up_valid = 4'hF;
    tick(1);
    m_if.up_valid = '0;
    rst = 1'b1;
    tick(1);
    chk("t5_beat", |m_beat, 0);
    chk("t5_err", |m_err, 0);
    chk("t5_any", m_any, 0);
    chk("t5_ready", m_if.up_ready, 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("t5_ready_up", m_if.up_ready, 4'hF);
    send(0, 0, 42, cyc);
    send(0, 0, 43, cyc);
    send(0, 0, 44, cyc);
    m_if.up_valid[0] = 1'b0;
    tick(2);
    chk("t5_beat_after", m_beat[15:0], 3);
    chk("t5_err_after", m_err[15:0], 0);
    chk("t5_any_after", m_any, 0);

    // DELAY=3 throttling on ch2
    tot = 0;
    for (int i = 0; i < 12; i++) begin
      send(1, 2, i, cyc);
      tot += cyc;
    end
    chk("t3_cycles", tot, 39);
    chk("t3_beat_mid", s_beat[47:32], 10);
    s_if.up_valid[2] = 1'b0;
    tick(20);
    chk("t3_beat", s_beat[47:32], 12);
    chk("t3_err", s_err[47:32], 0);

    // 8-bit wrap on ch3
    send(2, 3, 32'hFE, cyc);
    send(2, 3, 32'hFF, cyc);
    send(2, 3, 32'h00, cyc);
    send(2, 3, 32'h01, cyc);
    n_if.up_valid[3] = 1'b0;
    tick(2);
    chk("t4_err", n_err[15:12], 0);
    chk("t4_beat", n_beat[15:12], 4);
    chk("t4_any", n_any, 0);

    // saturation at 15, then clr coinciding with a mismatch
    for (int i = 0; i < 21; i++) send(2, 0, 32'h55, cyc);
    n_if.up_valid[0] = 1'b0;
    tick(2);
    chk("t6_err_sat", n_err[3:0], 15);
    chk("t6_beat_sat", n_beat[3:0], 15);
    chk("t6_any", n_any, 1);
    send(2, 0, 32'h55, cyc);
    n_if.up_valid[0] = 1'b0;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("t6_clr_pulse", n_pulse[0], 1);
    chk("t6_clr_err", n_err[3:0], 0);
    chk("t6_clr_beat", n_beat[3:0], 0);
    chk("t6_clr_any", n_any, 0);
    tick(1);
    chk("t6_pulse_off", n_pulse[0], 0);
    send(2, 0, 32'h56, cyc);
    n_if.up_valid[0] = 1'b0;
    tick(2);
    chk("t6_keep_err", n_err[3:0], 0);
    chk("t6_keep_beat", n_beat[3:0], 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
